reg_scoreboard: RTL and testbench

Register-hazard scoreboard and issue controller sitting between instruction decode and execute in the RV64 pipeline. It tracks which architectural registers (x1–x31) have a write in flight and holds decode off on RAW and WAW hazards. It also caps the number of outstanding register writes and releases each register when its writeback retires. Execute sees one registered issue pulse per accepted instruction.

---
 rtl/reg_scoreboard.sv | 119 +++++++++++
 tb/tb_reg_scoreboard.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between decode and execute: stalls decode on RAW/WAW hazards,
// caps outstanding register writes and emits a registered issue pulse per accepted instruction.
module reg_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_wen,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             iss_valid,
  output logic [4:0]       iss_rd,
  output logic             iss_wen,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] inflight,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_INFLIGHT);

  logic [31:1]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             iss_valid_q, iss_valid_d;
  logic [4:0]       iss_rd_q, iss_rd_d;
  logic             iss_wen_q, iss_wen_d;

  // Bit 0 is hard-wired clear so x0 never appears busy.
  logic [31:0] busy_full;
  assign busy_full = {busy_q, 1'b0};

  logic rd_tracked;
  logic raw, waw, full;
  logic fire, track;
  logic wb_nz, wb_hit, wb_miss;

  always_comb begin
    rd_tracked = dec_wen && (dec_rd != 5'd0);
    raw        = busy_full[dec_rs1] || (dec_use_rs2 && busy_full[dec_rs2]);
    waw        = rd_tracked && busy_full[dec_rd];
    full       = rd_tracked && (cnt_q == MaxCnt);
    dec_ready  = !flush && !raw && !waw && !full;
    fire       = dec_valid && dec_ready;
    track      = fire && rd_tracked;
    wb_nz      = wb_valid && (wb_rd != 5'd0);
    wb_hit     = wb_nz && busy_full[wb_rd];
    wb_miss    = wb_nz && !busy_full[wb_rd];
  end

  // Scoreboard next state: writeback clears first so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wb_hit) begin
        busy_d[wb_rd] = 1'b0;
      end
      if (track) begin
        busy_d[dec_rd] = 1'b1;
      end
      unique case ({track, wb_hit})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (wb_miss) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    iss_valid_d = fire;
    iss_rd_d    = iss_rd_q;
    iss_wen_d   = iss_wen_q;
    if (fire) begin
      iss_rd_d  = dec_rd;
      iss_wen_d = dec_wen;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_rd_q    <= 5'd0;
      iss_wen_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      iss_valid_q <= iss_valid_d;
      iss_rd_q    <= iss_rd_d;
      iss_wen_q   <= iss_wen_d;
    end
  end

  assign busy_mask = busy_full;
  assign inflight  = cnt_q;
  assign sb_err    = err_q;
  assign iss_valid = iss_valid_q;
  assign iss_rd    = iss_rd_q;
  assign iss_wen   = iss_wen_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic against a register-set model.
module tb_reg_scoreboard;

  localparam int MaxInflight = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        dec_valid, dec_use_rs2, dec_wen, wb_valid, flush;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_ready, iss_valid, iss_wen, sb_err;
  logic [4:0]  iss_rd;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;

  reg_scoreboard #(.MAX_INFLIGHT(MaxInflight), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_wen(dec_wen), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wen(iss_wen), .busy_mask(busy_mask),
    .inflight(inflight), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the set of registers with a write outstanding.
  bit       m_busy [32];
  bit       m_err;
  bit       m_iss_valid;
  bit [4:0] m_iss_rd;
  bit       m_iss_wen;
  bit       act_ready, exp_ready;

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 1; i < 32; i++) m[i] = m_busy[i];
    return m;
  endfunction

  function automatic bit m_ready();
    bit writes = dec_wen && dec_rd != 0;
    if (flush) return 0;
    if (m_busy[dec_rs1] || (dec_use_rs2 && m_busy[dec_rs2])) return 0;
    if (writes && m_busy[dec_rd]) return 0;
    if (writes && m_count() == MaxInflight) return 0;
    return 1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_err = 0; m_iss_valid = 0; m_iss_rd = 0; m_iss_wen = 0;
  endtask

  task automatic set_dec(input bit v, input int rs1, input int rs2, input bit u2,
                         input int rd, input bit wen);
    dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_use_rs2 = u2;
    dec_rd = 5'(rd); dec_wen = wen;
  endtask

  task automatic set_wb(input bit v, input int rd);
    wb_valid = v; wb_rd = 5'(rd);
  endtask

  // Called at posedge+1 with inputs already driven; samples dec_ready mid-cycle,
  // advances one edge, applies the architectural rules to the model, returns at posedge+1.
  task automatic tick();
    bit fire;
    #4;
    act_ready = dec_ready;
    exp_ready = m_ready();
    fire = dec_valid && exp_ready;
    @(posedge CLK);
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (m_busy[wb_rd]) m_busy[wb_rd] = 0;
        else m_err = 1;
      end
      if (fire && dec_wen && dec_rd != 0) m_busy[dec_rd] = 1;
    end
    m_iss_valid = fire;
    if (fire) begin
      m_iss_rd = dec_rd; m_iss_wen = dec_wen;
    end
    #1;
  endtask

  task automatic idle_inputs();
    set_dec(0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    flush = 0;
  endtask

  task automatic do_reset();
    RST_N = 0;
    #2;
    m_reset();
    @(posedge CLK); #1;
    RST_N = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 0;
    m_reset();
    #3;
    checks++;
    if ({iss_valid, iss_rd, iss_wen, busy_mask, inflight, sb_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: iss_v=%0b iss_rd=%0d iss_wen=%0b busy=%h infl=%0d err=%0b want 0",
               iss_valid, iss_rd, iss_wen, busy_mask, inflight, sb_err);
    end
    @(posedge CLK); #1;
    RST_N = 1;
    tick();
    checks++;
    if (act_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b want 1", act_ready);
    end
    checks++;
    if (iss_valid !== 1'b0 || busy_mask !== 32'h0 || inflight !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: iss_v=%0b busy=%h infl=%0d want 0", iss_valid, busy_mask, inflight);
    end
  endtask

  task automatic test_raw();
    set_dec(1, 0, 0, 0, 5, 1);
    tick();
    checks++;
    if (busy_mask !== 32'h20 || inflight !== 4'd1 || iss_valid !== 1'b1 || iss_rd !== 5'd5) begin
      errors++;
      $display("FAIL raw_issue: busy=%h infl=%0d iss_v=%0b iss_rd=%0d want 20/1/1/5",
               busy_mask, inflight, iss_valid, iss_rd);
    end
    set_dec(1, 5, 0, 0, 6, 0);
    tick();
    checks++;
    if (act_ready !== 1'b0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL raw_stall: ready=%0b iss_v=%0b want 0/0", act_ready, iss_valid);
    end
    set_wb(1, 5);  // cycle N: still stalled, no bypass
    tick();
    checks++;
    if (act_ready !== 1'b0 || busy_mask !== 32'h0) begin
      errors++; $display("FAIL raw_wb_cycle: ready=%0b busy=%h want 0/0", act_ready, busy_mask);
    end
    set_wb(0, 0);
    tick();
    checks++;
    if (act_ready !== 1'b1 || iss_valid !== 1'b1 || iss_wen !== 1'b0) begin
      errors++;
      $display("FAIL raw_release: ready=%0b iss_v=%0b iss_wen=%0b want 1/1/0",
               act_ready, iss_valid, iss_wen);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_waw_x0();
    set_dec(1, 0, 0, 0, 7, 1);
    tick();
    set_dec(1, 0, 0, 0, 7, 1);
    tick();
    checks++;
    if (act_ready !== 1'b0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL waw_stall: ready=%0b iss_v=%0b want 0/0", act_ready, iss_valid);
    end
    set_dec(1, 0, 0, 1, 0, 1);
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rd !== 5'd0 || busy_mask !== 32'h80 || inflight !== 4'd1) begin
      errors++;
      $display("FAIL x0_write: iss_v=%0b iss_rd=%0d busy=%h infl=%0d want 1/0/80/1",
               iss_valid, iss_rd, busy_mask, inflight);
    end
    set_dec(1, 0, 0, 0, 3, 0);
    tick();
    checks++;
    if (act_ready !== 1'b1 || iss_valid !== 1'b1) begin
      errors++; $display("FAIL rs1_x0: ready=%0b iss_v=%0b want 1/1", act_ready, iss_valid);
    end
    idle_inputs();
    set_wb(1, 7);
    tick();
    set_wb(0, 0);
    tick();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      set_dec(1, 0, 0, 0, r, 1);
      tick();
    end
    checks++;
    if (inflight !== 4'd4 || busy_mask !== 32'h1e) begin
      errors++; $display("FAIL cap_fill: infl=%0d busy=%h want 4/1e", inflight, busy_mask);
    end
    set_dec(1, 0, 0, 0, 9, 1);
    tick();
    checks++;
    if (act_ready !== 1'b0 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL cap_full_stall: ready=%0b iss_v=%0b want 0/0", act_ready, iss_valid);
    end
    set_dec(1, 10, 11, 1, 12, 0);
    tick();
    checks++;
    if (act_ready !== 1'b1 || iss_valid !== 1'b1 || inflight !== 4'd4) begin
      errors++;
      $display("FAIL cap_nowrite: ready=%0b iss_v=%0b infl=%0d want 1/1/4",
               act_ready, iss_valid, inflight);
    end
    set_dec(1, 0, 0, 0, 9, 1);
    set_wb(1, 2);
    tick();
    checks++;
    if (act_ready !== 1'b0 || inflight !== 4'd3) begin
      errors++; $display("FAIL cap_wb_full: ready=%0b infl=%0d want 0/3", act_ready, inflight);
    end
    set_wb(0, 0);
    tick();
    checks++;
    if (iss_valid !== 1'b1 || iss_rd !== 5'd9 || inflight !== 4'd4 || busy_mask !== 32'h21a) begin
      errors++;
      $display("FAIL cap_refire: iss_v=%0b iss_rd=%0d infl=%0d busy=%h want 1/9/4/21a",
               iss_valid, iss_rd, inflight, busy_mask);
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      set_wb(1, k == 0 ? 1 : k == 1 ? 3 : k == 2 ? 4 : 9);
      tick();
    end
    set_wb(0, 0);
    tick();
  endtask

  task automatic test_simul();
    set_dec(1, 0, 0, 0, 3, 1);
    tick();
    set_dec(1, 0, 0, 0, 6, 1);
    set_wb(1, 3);
    tick();
    checks++;
    if (busy_mask !== 32'h40 || inflight !== 4'd1 || iss_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_fire_wb: busy=%h infl=%0d iss_v=%0b want 40/1/1",
               busy_mask, inflight, iss_valid);
    end
    idle_inputs();
    set_wb(1, 6);
    tick();
    set_wb(0, 0);
  endtask

  task automatic test_async_reset();
    set_dec(1, 0, 0, 0, 11, 1);
    tick();
    idle_inputs();
    #2;
    RST_N = 0;
    m_reset();
    #1;
    checks++;
    if (iss_valid !== 1'b0 || busy_mask !== 32'h0 || inflight !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: iss_v=%0b busy=%h infl=%0d want 0", iss_valid, busy_mask, inflight);
    end
    @(posedge CLK); #1;
    RST_N = 1;
  endtask

  task automatic test_flush_err();
    set_dec(1, 0, 0, 0, 1, 1);
    tick();
    set_dec(1, 0, 0, 0, 8, 1);
    tick();
    set_dec(1, 0, 0, 0, 12, 1);
    flush = 1;
    tick();
    checks++;
    if (act_ready !== 1'b0 || iss_valid !== 1'b0 || busy_mask !== 32'h0 || inflight !== 4'd0) begin
      errors++;
      $display("FAIL flush: ready=%0b iss_v=%0b busy=%h infl=%0d want 0/0/0/0",
               act_ready, iss_valid, busy_mask, inflight);
    end
    idle_inputs();
    set_wb(1, 8);
    tick();
    set_wb(0, 0);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++; $display("FAIL sticky_err: got %0b want 1", sb_err);
    end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (sb_err !== 1'b1) begin
      errors++; $display("FAIL err_survives_flush: got %0b want 1", sb_err);
    end
    do_reset();
    checks++;
    if (sb_err !== 1'b0) begin
      errors++; $display("FAIL err_reset: got %0b want 0", sb_err);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      set_wb(0, 0);
      if (!flush && $urandom_range(0, 2) == 0) begin
        int pick = $urandom_range(0, 7);
        if ($urandom_range(0, 7) != 0) begin
          for (int j = 0; j < 8; j++) begin
            if (m_busy[(pick + j) % 8] && ((pick + j) % 8) != 0) begin
              pick = (pick + j) % 8;
              break;
            end
          end
        end
        set_wb(1, pick);
      end
      tick();
      checks++;
      if (act_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, act_ready, exp_ready);
      end
      checks++;
      if (iss_valid !== m_iss_valid || iss_rd !== m_iss_rd || iss_wen !== m_iss_wen) begin
        errors++;
        $display("FAIL rnd_issue c=%0d: got %0b/%0d/%0b want %0b/%0d/%0b", c, iss_valid, iss_rd,
                 iss_wen, m_iss_valid, m_iss_rd, m_iss_wen);
      end
      checks++;
      if (busy_mask !== m_mask() || inflight !== 4'(m_count()) || sb_err !== m_err) begin
        errors++;
        $display("FAIL rnd_state c=%0d: busy=%h infl=%0d err=%0b want %h/%0d/%0b", c, busy_mask,
                 inflight, sb_err, m_mask(), m_count(), m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw_x0();
    test_capacity();
    test_simul();
    test_async_reset();
    test_flush_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
